uart_rx_param: RTL and testbench

//  Parametrised UART receiver; next generation of the fixed 7-bit Hamming receiver.

---
 rtl/uart_rx_param.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop rx synchroniser, oversampled start/bit
// centre sampling, optional parity, 1 or 2 stop bits, per-word error flags
// and a valid/ready output holding register with overrun detection.
module uart_rx_param #(
   parameter int unsigned DATA_BITS  = 7,
   parameter int unsigned OVERSAMPLE = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 rx,
   input  logic                 ready_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic [2:0]           state_out
);

   localparam int unsigned HALF = OVERSAMPLE / 2;
   localparam int unsigned SCW  = $clog2(OVERSAMPLE);
   localparam int unsigned BCW  = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_meta_q, rx_s_q;
   logic [SCW-1:0]       sample_cnt_q, sample_cnt_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;
   logic                 ovr_q, ovr_d;
   logic                 bit_centre;
   logic                 commit;

   assign bit_centre = (sample_cnt_q == SCW'(OVERSAMPLE - 1));

   // Next-state logic: receive FSM advances on ena ticks, handshake every clk.
   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      armed_d      = armed_q;
      commit       = 1'b0;

      if (ena) begin
         case (state_q)
            S_IDLE: begin
               if (armed_q && !rx_s_q) begin
                  state_d      = S_START;
                  sample_cnt_d = '0;
               end else if (!armed_q && rx_s_q) begin
                  armed_d = 1'b1;
               end
            end
            S_START: begin
               if (sample_cnt_q == SCW'(HALF - 1)) begin
                  sample_cnt_d = '0;
                  if (rx_s_q) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d   = S_DATA;
                     bit_cnt_d = '0;
                     perr_d    = 1'b0;
                     ferr_d    = 1'b0;
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
            S_DATA: begin
               if (bit_centre) begin
                  sample_cnt_d = '0;
                  shift_d      = {rx_s_q, shift_q[DATA_BITS-1:1]};
                  if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                     bit_cnt_d = '0;
                     state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BCW'(1);
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
            S_PARITY: begin
               if (bit_centre) begin
                  sample_cnt_d = '0;
                  perr_d       = ((^shift_q) ^ rx_s_q) != (PARITY_ODD != 0);
                  state_d      = S_STOP;
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
            S_STOP: begin
               if (bit_centre) begin
                  sample_cnt_d = '0;
                  ferr_d       = ferr_q | !rx_s_q;
                  if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
                     commit    = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = S_IDLE;
                     if (ferr_d) armed_d = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BCW'(1);
                  end
               end else begin
                  sample_cnt_d = sample_cnt_q + SCW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      data_d     = data_q;
      valid_d    = valid_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      ovr_d      = ovr_q;
      // A commit wins over an accept in the same clk; the old word is overrun
      // only if it was still pending and not being taken this cycle.
      if (commit) begin
         data_d     = shift_q;
         valid_d    = 1'b1;
         perr_out_d = perr_q;
         ferr_out_d = ferr_d;
         ovr_d      = valid_q && !ready_in;
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
   end

   // All state, synchroniser and output registers; async active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= S_IDLE;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         armed_q      <= 1'b1;
         data_q       <= '0;
         valid_q      <= 1'b0;
         perr_out_q   <= 1'b0;
         ferr_out_q   <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         armed_q      <= armed_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         perr_out_q   <= perr_out_d;
         ferr_out_q   <= ferr_out_d;
         ovr_q        <= ovr_d;
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign parity_err = perr_out_q;
   assign frame_err  = ferr_out_q;
   assign overrun    = ovr_q;
   assign state_out  = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (defaults; 8 data bits with
// even parity; 2 stop bits with ena every 3rd clk) sharing one scoreboard.
module tb_uart_rx_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] rx_v;
   logic [2:0] ena_v;
   logic [2:0] rdy_v;

   logic [6:0] d0;  logic v0, pe0, fe0, ov0;  logic [2:0] st0;
   logic [7:0] d1;  logic v1, pe1, fe1, ov1;  logic [2:0] st1;
   logic [6:0] d2;  logic v2, pe2, fe2, ov2;  logic [2:0] st2;

   int n_cmp = 0;
   int n_bad = 0;
   int ena_cnt = 0;

   typedef struct {
      int         dut;
      logic [8:0] data;
      logic       pe;
      logic       fe;
      logic       ov;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   uart_rx_param u_dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[0]), .rx(rx_v[0]), .ready_in(rdy_v[0]),
      .data_out(d0), .valid_out(v0), .parity_err(pe0), .frame_err(fe0),
      .overrun(ov0), .state_out(st0));

   uart_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[1]), .rx(rx_v[1]), .ready_in(rdy_v[1]),
      .data_out(d1), .valid_out(v1), .parity_err(pe1), .frame_err(fe1),
      .overrun(ov1), .state_out(st1));

   uart_rx_param #(.STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena_v[2]), .rx(rx_v[2]), .ready_in(rdy_v[2]),
      .data_out(d2), .valid_out(v2), .parity_err(pe2), .frame_err(fe2),
      .overrun(ov2), .state_out(st2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int dut, input logic [8:0] d, input logic pe, input logic fe,
                       input logic ov);
      exp_t e;
      e.dut = dut; e.data = d; e.pe = pe; e.fe = fe; e.ov = ov;
      sb_q.push_back(e);
   endtask

   task automatic check_word(input int dut, input logic [8:0] d, input logic v,
                             input logic pe, input logic fe, input logic ov);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_word: dut%0d got data %0h, expected no word", dut, d);
      end else begin
         e = sb_q.pop_front();
         chk("word_dut", dut, e.dut);
         chk("word_data", {23'd0, d}, {23'd0, e.data});
         chk("word_valid", {31'd0, v}, 32'd1);
         chk("word_parity_err", {31'd0, pe}, {31'd0, e.pe});
         chk("word_frame_err", {31'd0, fe}, {31'd0, e.fe});
         chk("word_overrun", {31'd0, ov}, {31'd0, e.ov});
      end
   endtask

   // Monitors: a commit shows up as the STOP -> IDLE transition.
   logic [2:0] p0 = 3'd0, p1 = 3'd0, p2 = 3'd0;
   always @(negedge clk) begin
      if (p0 == 3'd4 && st0 == 3'd0) check_word(0, {2'b0, d0}, v0, pe0, fe0, ov0);
      p0 <= st0;
   end
   always @(negedge clk) begin
      if (p1 == 3'd4 && st1 == 3'd0) check_word(1, {1'b0, d1}, v1, pe1, fe1, ov1);
      p1 <= st1;
   end
   always @(negedge clk) begin
      if (p2 == 3'd4 && st2 == 3'd0) check_word(2, {2'b0, d2}, v2, pe2, fe2, ov2);
      p2 <= st2;
   end

   // ena for the third receiver: one tick every 3rd clk.
   initial begin
      ena_v[2] = 1'b0;
      forever begin
         @(negedge clk);
         ena_cnt  = (ena_cnt == 2) ? 0 : ena_cnt + 1;
         ena_v[2] = (ena_cnt == 0);
      end
   end

   task automatic bit_time(input int dut, input logic b, input int cpb);
      rx_v[dut] = b;
      repeat (cpb) @(negedge clk);
   endtask

   task automatic send_frame(input int dut, input int nbits, input logic [8:0] data,
                             input int has_par, input logic par_bit, input int nstop,
                             input logic [1:0] stops, input int cpb);
      bit_time(dut, 1'b0, cpb);
      for (int i = 0; i < nbits; i++) bit_time(dut, data[i], cpb);
      if (has_par != 0) bit_time(dut, par_bit, cpb);
      for (int i = 0; i < nstop; i++) bit_time(dut, stops[i], cpb);
      bit_time(dut, 1'b1, cpb);
   endtask

   initial begin
      rst_n = 1'b0;
      rx_v  = 3'b111;
      rdy_v = 3'b111;
      ena_v[0] = 1'b1;
      ena_v[1] = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_valid", {31'd0, v0}, 32'd0);
      chk("reset_data", {25'd0, d0}, 32'd0);
      chk("reset_flags", {29'd0, pe0, fe0, ov0}, 32'd0);
      chk("reset_state", {29'd0, st0}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Short low glitches on an idle line must be rejected as false starts.
      bit_time(0, 1'b0, 1);
      bit_time(0, 1'b1, 16);
      bit_time(0, 1'b0, 3);
      bit_time(0, 1'b1, 16);
      chk("glitch_state", {29'd0, st0}, 32'd0);
      chk("glitch_valid", {31'd0, v0}, 32'd0);

      // Clean default frame.
      push(0, 9'h05A, 1'b0, 1'b0, 1'b0);
      send_frame(0, 7, 9'h05A, 0, 1'b0, 1, 2'b11, 8);

      // Stop bit low, line then held low for 40 more ticks: no restart allowed.
      push(0, 9'h033, 1'b0, 1'b1, 1'b0);
      bit_time(0, 1'b0, 8);
      for (int i = 0; i < 7; i++) bit_time(0, (i == 0 || i == 1 || i == 4 || i == 5), 8);
      bit_time(0, 1'b0, 8 + 40);
      chk("disarmed_state", {29'd0, st0}, 32'd0);
      bit_time(0, 1'b1, 16);
      push(0, 9'h02B, 1'b0, 1'b0, 1'b0);
      send_frame(0, 7, 9'h02B, 0, 1'b0, 1, 2'b11, 8);

      // Overrun: sink stalled across two words.
      rdy_v[0] = 1'b0;
      push(0, 9'h011, 1'b0, 1'b0, 1'b0);
      send_frame(0, 7, 9'h011, 0, 1'b0, 1, 2'b11, 8);
      push(0, 9'h022, 1'b0, 1'b0, 1'b1);
      send_frame(0, 7, 9'h022, 0, 1'b0, 1, 2'b11, 8);
      chk("stall_valid", {31'd0, v0}, 32'd1);
      rdy_v[0] = 1'b1;
      @(negedge clk);
      chk("accept_valid", {31'd0, v0}, 32'd0);
      chk("accept_overrun_hold", {31'd0, ov0}, 32'd1);
      chk("accept_data_hold", {25'd0, d0}, 32'h22);

      // Even parity, 8 data bits: bad then good parity bit.
      push(1, 9'h0A5, 1'b1, 1'b0, 1'b0);
      send_frame(1, 8, 9'h0A5, 1, 1'b1, 1, 2'b11, 8);
      push(1, 9'h0A5, 1'b0, 1'b0, 1'b0);
      send_frame(1, 8, 9'h0A5, 1, 1'b0, 1, 2'b11, 8);

      // Two stop bits, slow ticks: good frame, then second stop bit low.
      push(2, 9'h04C, 1'b0, 1'b0, 1'b0);
      send_frame(2, 7, 9'h04C, 0, 1'b0, 2, 2'b11, 24);
      push(2, 9'h019, 1'b0, 1'b1, 1'b0);
      send_frame(2, 7, 9'h019, 0, 1'b0, 2, 2'b01, 24);
      chk("stop2_ferr_hold", {31'd0, fe2}, 32'd1);

      // Reset in the middle of the data bits discards the partial frame.
      bit_time(2, 1'b0, 24);
      bit_time(2, 1'b1, 24);
      bit_time(2, 1'b0, 24);
      bit_time(2, 1'b1, 12);
      chk("mid_data_state", {29'd0, st2}, 32'd2);
      rst_n = 1'b0;
      #2;
      chk("rst_state", {29'd0, st2}, 32'd0);
      chk("rst_outputs", {28'd0, v2, pe2, fe2, ov2}, 32'd0);
      chk("rst_data", {25'd0, d2}, 32'd0);
      rx_v[2] = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("post_rst_state", {29'd0, st2}, 32'd0);
      chk("post_rst_valid", {31'd0, v2}, 32'd0);

      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
